// File: rtl/shift_reg_univ_n.sv
// Universal shift register (hold / shift-up / shift-down / load) with a shift-frame counter and Done pulse.
// Optional macro SHIFT_ROTATE_EN: Rotate=1 recirculates the end bit instead of taking SinLo/SinHi.
module shift_reg_univ_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic             SinLo,
  input  logic             SinHi,
  input  logic [WIDTH-1:0] D,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Q,
  output logic             SoutUp,
  output logic             SoutDn,
  output logic [CNT_W-1:0] Count,
  output logic             Done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             fill_lo;
  logic             fill_hi;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] count_next;
  logic             done_next;
  logic             shift;

`ifdef SHIFT_ROTATE_EN
  assign fill_lo = Rotate ? Q[WIDTH-1] : SinLo;
  assign fill_hi = Rotate ? Q[0]       : SinHi;
`else
  logic unused_rotate;
  assign unused_rotate = Rotate;
  assign fill_lo = SinLo;
  assign fill_hi = SinHi;
`endif

  always_comb begin
    q_next     = Q;
    count_next = Count;
    done_next  = 1'b0;
    shift      = 1'b0;
    case (Mode)
      MODE_HOLD: ;
      MODE_UP: begin
        q_next = {Q[WIDTH-2:0], fill_lo};
        shift  = 1'b1;
      end
      MODE_DOWN: begin
        q_next = {fill_hi, Q[WIDTH-1:1]};
        shift  = 1'b1;
      end
      MODE_LOAD: begin
        q_next     = D;
        count_next = '0;
      end
      default: ;
    endcase
    // Counter saturates at a full frame; Done fires only on the transition into it.
    if (shift && Count != CNT_FULL) begin
      count_next = Count + 1'b1;
      done_next  = (Count == CNT_LAST);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q     <= '0;
      Count <= '0;
      Done  <= 1'b0;
    end else begin
      Q     <= q_next;
      Count <= count_next;
      Done  <= done_next;
    end
  end

  assign SoutUp = Q[WIDTH-1];
  assign SoutDn = Q[0];

endmodule

// File: tb/tb_shift_reg_univ_n.sv
// Directed table-driven bench for shift_reg_univ_n at WIDTH=4, plus rotate corner sequence.
module tb_shift_reg_univ_n;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             sin_lo;
  logic             sin_hi;
  logic [WIDTH-1:0] d;
  logic             rotate;
  logic [WIDTH-1:0] q;
  logic             sout_up;
  logic             sout_dn;
  logic [CNT_W-1:0] count;
  logic             done;

  shift_reg_univ_n #(.WIDTH(WIDTH)) dut (
    .Clock (clock),
    .Reset (reset),
    .Mode  (mode),
    .SinLo (sin_lo),
    .SinHi (sin_hi),
    .D     (d),
    .Rotate(rotate),
    .Q     (q),
    .SoutUp(sout_up),
    .SoutDn(sout_dn),
    .Count (count),
    .Done  (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [1:0] md;
    logic       slo;
    logic       shi;
    logic [3:0] din;
    logic [3:0] exp_q;
    int         exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [1:0] m, input logic lo, input logic hi,
                     input logic [3:0] dd, input logic [3:0] eq, input int ec, input logic ed);
    vec_t v;
    v.rst = r; v.md = m; v.slo = lo; v.shi = hi; v.din = dd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
  endtask

  // Drive on the falling edge, one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [1:0] m, input logic lo, input logic hi,
                      input logic [3:0] dd, input logic rot);
    @(negedge clock);
    reset = r; mode = m; sin_lo = lo; sin_hi = hi; d = dd; rotate = rot;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] eq,
                         input int ec, input logic ed);
    chk({tag, "_q"},     idx, int'(q),       int'(eq));
    chk({tag, "_count"}, idx, int'(count),   ec);
    chk({tag, "_done"},  idx, int'(done),    int'(ed));
    chk({tag, "_soutup"},idx, int'(sout_up), int'(eq[3]));
    chk({tag, "_soutdn"},idx, int'(sout_dn), int'(eq[0]));
  endtask

  initial begin
    reset = 1'b0; mode = 2'b00; sin_lo = 1'b0; sin_hi = 1'b0; d = '0; rotate = 1'b0;

    //  rst mode  lo hi  d        exp_q    cnt done
    add(1, 2'b11, 0, 0, 4'hF,    4'b0000, 0, 0); // reset beats load
    add(0, 2'b01, 1, 0, 4'h0,    4'b0001, 1, 0); // SIPO 1,0,1,1
    add(0, 2'b01, 0, 0, 4'h0,    4'b0010, 2, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b0101, 3, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b1011, 4, 1);
    add(0, 2'b01, 0, 0, 4'h0,    4'b0110, 4, 0); // saturated, no second Done
    add(0, 2'b11, 0, 0, 4'b1001, 4'b1001, 0, 0); // PISO down, SoutDn 1,0,0,1
    add(0, 2'b10, 0, 0, 4'h0,    4'b0100, 1, 0);
    add(0, 2'b10, 0, 0, 4'h0,    4'b0010, 2, 0);
    add(0, 2'b10, 0, 0, 4'h0,    4'b0001, 3, 0);
    add(0, 2'b10, 0, 0, 4'h0,    4'b0000, 4, 1);
    add(0, 2'b11, 0, 0, 4'b1010, 4'b1010, 0, 0); // hold keeps Q/Count
    add(0, 2'b00, 1, 1, 4'h0,    4'b1010, 0, 0);
    add(0, 2'b00, 1, 1, 4'h0,    4'b1010, 0, 0);
    add(0, 2'b00, 1, 1, 4'h0,    4'b1010, 0, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b0101, 1, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b1011, 2, 0);
    add(0, 2'b00, 0, 0, 4'h0,    4'b1011, 2, 0);
    add(0, 2'b11, 0, 0, 4'b0000, 4'b0000, 0, 0); // load on would-be frame edge
    add(0, 2'b01, 1, 0, 4'h0,    4'b0001, 1, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b0011, 2, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b0111, 3, 0);
    add(0, 2'b11, 0, 0, 4'b0110, 4'b0110, 0, 0);
    add(0, 2'b00, 0, 0, 4'h0,    4'b0110, 0, 0);
    add(0, 2'b01, 0, 0, 4'h0,    4'b1100, 1, 0); // reset mid-frame
    add(0, 2'b01, 0, 0, 4'h0,    4'b1000, 2, 0);
    add(0, 2'b01, 0, 0, 4'h0,    4'b0000, 3, 0);
    add(1, 2'b01, 1, 0, 4'h0,    4'b0000, 0, 0);
    add(0, 2'b11, 0, 0, 4'b0011, 4'b0011, 0, 0); // mixed directions, one frame
    add(0, 2'b01, 0, 0, 4'h0,    4'b0110, 1, 0);
    add(0, 2'b10, 0, 1, 4'h0,    4'b1011, 2, 0);
    add(0, 2'b01, 1, 0, 4'h0,    4'b0111, 3, 0);
    add(0, 2'b10, 0, 0, 4'h0,    4'b0011, 4, 1);
    add(0, 2'b00, 0, 0, 4'h0,    4'b0011, 4, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].md, vecs[i].slo, vecs[i].shi, vecs[i].din, 1'b0);
      chk_all("vec", i, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // Rotate sequence: load 1000, four shift-ups with Rotate=1, then one rotate-down with SinHi=1.
    step(0, 2'b11, 0, 0, 4'b1000, 1'b1);
    chk_all("rot_load", 0, 4'b1000, 0, 0);
    begin
      logic [3:0] exp_up [4];
`ifdef SHIFT_ROTATE_EN
      exp_up[0] = 4'b0001; exp_up[1] = 4'b0010; exp_up[2] = 4'b0100; exp_up[3] = 4'b1000;
`else
      exp_up[0] = 4'b0000; exp_up[1] = 4'b0000; exp_up[2] = 4'b0000; exp_up[3] = 4'b0000;
`endif
      for (int k = 0; k < 4; k++) begin
        step(0, 2'b01, 0, 0, 4'h0, 1'b1);
        chk_all("rot_up", k, exp_up[k], k + 1, (k == 3) ? 1'b1 : 1'b0);
      end
    end
    step(0, 2'b00, 1, 1, 4'h0, 1'b1);
`ifdef SHIFT_ROTATE_EN
    chk_all("rot_hold", 0, 4'b1000, 4, 0);
    step(0, 2'b10, 0, 1, 4'h0, 1'b1);
    chk_all("rot_down", 0, 4'b0100, 4, 0);
`else
    chk_all("rot_hold", 0, 4'b0000, 4, 0);
    step(0, 2'b10, 0, 1, 4'h0, 1'b1);
    chk_all("rot_down", 0, 4'b1000, 4, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
